fpu_issuer: RTL and testbench
=============================

// Module: fpu_issuer
// PURPOSE
//  Initiator-side sequencer for the fpu top. Accepts one op per valid/ready handshake, clears the target
//  unit, drives operands/opcode/rounding with act high, waits for done (or timeout), latches result and
//  flags, and returns them on a valid/ready response port. One op in flight; sits between core and fpu.
// PARAMETERS
//  RST_CYC  2    cycles fpu_rst held high before act (>=1)
//  TIMEOUT  64   max RUN cycles waiting for done before forced response (16-bit)
//  TAG_W    4    request/response tag width
// PORTS
//  clk         in   1      clock
//  rst         in   1      asynchronous reset, active-low
//  req_valid   in   1      request valid
//  req_ready   out  1      request accepted when valid&ready
//  req_op      in   3      0 add, 1 mul, 2 div, 3 sqrt, 4 compare
//  req_a/req_b in   32     operands (req_b ignored for sqrt)
//  req_rm      in   3      rounding mode
//  req_tag     in   TAG_W  returned unchanged on rsp_tag
//  in1p/in2p   out  32     fpu operands
//  opcode      out  3      fpu opcode
//  round_mp    out  3      fpu rounding mode
//  act         out  1      fpu activate
//  fpu_rst     out  1      fpu unit clear (drives fpu rstp), active-high
//  out         in   32     fpu result
//  ov,un,inv,inexact,div_zero,less,eq,great,done  in 1 each, fpu status
//  rsp_valid   out  1      response valid
//  rsp_ready   in   1      response consumed when valid&ready
//  rsp_data    out  32     result; compare: {29'd0,great,eq,less}
//  rsp_flags   out  5      {inv,div_zero,ov,un,inexact} of this op
//  rsp_tag     out  TAG_W  tag of this op
//  rsp_timeout out  1      op ended by timeout
// BEHAVIOUR
//  Reset (rst low, async): state IDLE; all outputs 0 except req_ready=1; counters cleared.
//  FSM IDLE->CLR->RUN->RESP->IDLE.
//  IDLE: req_ready=1. On accept (cycle 0) latch op/a/b/rm/tag. req_op>4: go RESP directly next cycle,
//   rsp_data=0x7FC00000, rsp_flags=5'b10000, no fpu activity. Else -> CLR.
//  CLR: fpu_rst=1, act=0, operands/opcode/round_mp driven from latch, RST_CYC cycles, then RUN.
//  RUN: fpu_rst=0, act=1, operands held stable. done sampled every RUN cycle; done=1 in cycle N ->
//   capture out/flags/compare bits, RESP at N+1. Cycle counter reaches TIMEOUT without done ->
//   RESP with rsp_timeout=1, rsp_data=0x7FC00000, rsp_flags=5'b10000.
//  RESP: act=0, operand/opcode outputs go 0; rsp_valid=1, data stable until rsp_ready; on
//   valid&ready -> IDLE (req_ready=1 next cycle; no same-cycle accept).
//  Minimum latency accept->rsp_valid: RST_CYC+2 cycles (done in first RUN cycle).
//  rsp_flags for compare: inv only; other bits 0. sqrt: div_zero forced 0.
//  done asserted in CLR or IDLE ignored. rsp_ready while rsp_valid=0 ignored.
//  Async reset mid-op aborts: no response issued, fpu_rst/act drop immediately.
// CONFIGURATION
//  FPU_ISSUER_STICKY_EN: adds in clr_flags (1) and out sticky_flags (5): OR of rsp_flags of every
//   completed response handshake; clr_flags clears; clr_flags with same-cycle handshake -> value =
//   new rsp_flags only. Reset 0. Without macro: ports absent, no sticky state.
// TESTING
//  add 0x3F800000+0x40000000 rm=0, tag=3 -> rsp_data 0x40400000, flags 0, tag 3, timeout 0
//  div 0x3F800000/0x00000000 -> rsp_data 0x7F800000, flags[3] (div_zero)=1
//  compare 0x40000000 vs 0x3F800000 -> rsp_data 0x00000004; req_op=5 -> 0x7FC00000, flags 5'b10000
//  fpu done tied 0, TIMEOUT=8 -> rsp_timeout=1 exactly 8 RUN cycles after act rises
//  rsp_ready low 10 cycles -> rsp_valid/rsp_data stable, req_ready stays 0
//  rst low during RUN -> act=0, rsp_valid=0, req_ready=1 asynchronously; next op completes correctly

Source files
------------

// File: rtl/fpu_issuer.sv
// fpu_issuer: initiator-side sequencer between the core and the fpu.
// One operation is in flight at a time:
//   accept request -> clear the fpu -> run the fpu -> return the response.
//
// Ports
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   req_valid_i / req_ready_o       request handshake
//   req_op_i, req_a_i, req_b_i,
//   req_rm_i, req_tag_i             request payload (op 0 add, 1 mul, 2 div, 3 sqrt, 4 compare)
//   in1p_o, in2p_o, opcode_o,
//   round_mp_o, act_o, fpu_rst_o    fpu drive
//   out_i, ov_i, un_i, inv_i,
//   inexact_i, div_zero_i, less_i,
//   eq_i, great_i, done_i           fpu result and status
//   rsp_valid_o / rsp_ready_i       response handshake
//   rsp_data_o, rsp_flags_o,
//   rsp_tag_o, rsp_timeout_o        response payload; rsp_flags = {inv,div_zero,ov,un,inexact}
//
// Optional feature (macro FPU_ISSUER_STICKY_EN)
//   clr_flags_i, sticky_flags_o     accumulated OR of the flags of all completed responses
//
// state | meaning
// IDLE  | ready for a request
// CLR   | fpu held in clear for RST_CYC cycles, operands already driven
// RUN   | act high, waiting for done or for the timeout
// RESP  | response presented until consumed
module fpu_issuer #(
  parameter int RST_CYC = 2,
  parameter int TIMEOUT = 64,
  parameter int TAG_W   = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_op_i,
  input  logic [31:0]      req_a_i,
  input  logic [31:0]      req_b_i,
  input  logic [2:0]       req_rm_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic [31:0]      in1p_o,
  output logic [31:0]      in2p_o,
  output logic [2:0]       opcode_o,
  output logic [2:0]       round_mp_o,
  output logic             act_o,
  output logic             fpu_rst_o,
  input  logic [31:0]      out_i,
  input  logic             ov_i,
  input  logic             un_i,
  input  logic             inv_i,
  input  logic             inexact_i,
  input  logic             div_zero_i,
  input  logic             less_i,
  input  logic             eq_i,
  input  logic             great_i,
  input  logic             done_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_data_o,
  output logic [4:0]       rsp_flags_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_timeout_o
`ifdef FPU_ISSUER_STICKY_EN
  ,
  input  logic             clr_flags_i,
  output logic [4:0]       sticky_flags_o
`endif
);

  typedef enum logic [1:0] {IDLE, CLR, RUN, RESP} state_t;

  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [4:0]  INV_ONLY = 5'b10000;
  localparam logic [2:0]  OP_SQRT  = 3'd3;
  localparam logic [2:0]  OP_CMP   = 3'd4;
  localparam logic [15:0] CLR_LD   = 16'(RST_CYC - 1);
  localparam logic [15:0] RUN_LD   = 16'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [2:0]         rm_q, rm_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [31:0]        data_q, data_d;
  logic [4:0]         flags_q, flags_d;
  logic               tmo_q, tmo_d;
  logic               rsp_hs;

  assign rsp_hs = (state_q == RESP) && rsp_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rm_q    <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      flags_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rm_q    <= rm_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    rm_d          = rm_q;
    tag_d         = tag_q;
    data_d        = data_q;
    flags_d       = flags_q;
    tmo_d         = tmo_q;
    req_ready_o   = 1'b0;
    in1p_o        = '0;
    in2p_o        = '0;
    opcode_o      = '0;
    round_mp_o    = '0;
    act_o         = 1'b0;
    fpu_rst_o     = 1'b0;
    rsp_valid_o   = 1'b0;
    rsp_data_o    = '0;
    rsp_flags_o   = '0;
    rsp_tag_o     = '0;
    rsp_timeout_o = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          op_d  = req_op_i;
          a_d   = req_a_i;
          b_d   = req_b_i;
          rm_d  = req_rm_i;
          tag_d = req_tag_i;
          tmo_d = 1'b0;
          if (req_op_i > OP_CMP) begin
            // unsupported opcode: answer immediately, fpu untouched
            data_d  = QNAN;
            flags_d = INV_ONLY;
            state_d = RESP;
          end else begin
            cnt_d   = CLR_LD;
            state_d = CLR;
          end
        end
      end
      CLR: begin
        fpu_rst_o  = 1'b1;
        in1p_o     = a_q;
        in2p_o     = b_q;
        opcode_o   = op_q;
        round_mp_o = rm_q;
        if (cnt_q == '0) begin
          cnt_d   = RUN_LD;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      RUN: begin
        act_o      = 1'b1;
        in1p_o     = a_q;
        in2p_o     = b_q;
        opcode_o   = op_q;
        round_mp_o = rm_q;
        if (done_i) begin
          state_d = RESP;
          tmo_d   = 1'b0;
          if (op_q == OP_CMP) begin
            data_d  = {29'd0, great_i, eq_i, less_i};
            flags_d = {inv_i, 4'b0000};
          end else begin
            data_d  = out_i;
            flags_d = {inv_i, div_zero_i & (op_q != OP_SQRT), ov_i, un_i, inexact_i};
          end
        end else if (cnt_q == '0) begin
          // done never arrived within TIMEOUT run cycles
          state_d = RESP;
          tmo_d   = 1'b1;
          data_d  = QNAN;
          flags_d = INV_ONLY;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      RESP: begin
        rsp_valid_o   = 1'b1;
        rsp_data_o    = data_q;
        rsp_flags_o   = flags_q;
        rsp_tag_o     = tag_q;
        rsp_timeout_o = tmo_q;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FPU_ISSUER_STICKY_EN
  logic [4:0] sticky_q, sticky_d;

  // a clear coinciding with a handshake keeps only the new response's flags
  always_comb begin
    sticky_d = sticky_q;
    if (rsp_hs)           sticky_d = (clr_flags_i ? 5'b0 : sticky_q) | flags_q;
    else if (clr_flags_i) sticky_d = 5'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sticky_q <= '0;
    else         sticky_q <= sticky_d;
  end

  assign sticky_flags_o = sticky_q;
`else
  logic unused_hs;
  assign unused_hs = rsp_hs;
`endif

endmodule

// File: tb/tb_fpu_issuer.sv
module tb_fpu_issuer;
  localparam int RST_CYC = 2;
  localparam int TIMEOUT = 8;
  localparam int TAG_W   = 4;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic req_valid_i = 1'b0;
  logic req_ready_o;
  logic [2:0] req_op_i = '0;
  logic [31:0] req_a_i = '0, req_b_i = '0;
  logic [2:0] req_rm_i = '0;
  logic [TAG_W-1:0] req_tag_i = '0;
  logic [31:0] in1p_o, in2p_o;
  logic [2:0] opcode_o, round_mp_o;
  logic act_o, fpu_rst_o;
  logic [31:0] out_i;
  logic ov_i, un_i, inv_i, inexact_i, div_zero_i, less_i, eq_i, great_i, done_i;
  logic rsp_valid_o;
  logic rsp_ready_i = 1'b0;
  logic [31:0] rsp_data_o;
  logic [4:0] rsp_flags_o;
  logic [TAG_W-1:0] rsp_tag_o;
  logic rsp_timeout_o;
`ifdef FPU_ISSUER_STICKY_EN
  logic clr_flags_i = 1'b0;
  logic [4:0] sticky_flags_o;
  logic clr_with_hs = 1'b0;
`endif
  logic [4:0] sticky_m = '0;

  // fake fpu: returns fpu_out/fpu_st, raising done in RUN cycle fpu_lat (0 = never)
  logic [31:0] fpu_out = '0;
  logic [7:0]  fpu_st = '0;  // {ov,un,inv,inexact,div_zero,less,eq,great}
  int          fpu_lat = 1;
  logic        done_force = 1'b0;
  int          act_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    act_cnt <= 0;
    else if (act_o) act_cnt <= act_cnt + 1;
    else            act_cnt <= 0;
  end

  assign out_i = fpu_out;
  assign {ov_i, un_i, inv_i, inexact_i, div_zero_i, less_i, eq_i, great_i} = fpu_st;
  assign done_i = (done_force & ~act_o) | (act_o && fpu_lat != 0 && act_cnt == fpu_lat - 1);

  fpu_issuer #(.RST_CYC(RST_CYC), .TIMEOUT(TIMEOUT), .TAG_W(TAG_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_rm_i(req_rm_i), .req_tag_i(req_tag_i),
    .in1p_o(in1p_o), .in2p_o(in2p_o), .opcode_o(opcode_o), .round_mp_o(round_mp_o),
    .act_o(act_o), .fpu_rst_o(fpu_rst_o), .out_i(out_i),
    .ov_i(ov_i), .un_i(un_i), .inv_i(inv_i), .inexact_i(inexact_i), .div_zero_i(div_zero_i),
    .less_i(less_i), .eq_i(eq_i), .great_i(great_i), .done_i(done_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_flags_o(rsp_flags_o), .rsp_tag_o(rsp_tag_o), .rsp_timeout_o(rsp_timeout_o)
`ifdef FPU_ISSUER_STICKY_EN
    , .clr_flags_i(clr_flags_i), .sticky_flags_o(sticky_flags_o)
`endif
  );

  // One complete transaction with a reference prediction derived from the operation rules.
  // rdy_dly < 0: rsp_ready held high before the response appears.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] rm, input logic [TAG_W-1:0] tag, input logic [31:0] fout,
                       input logic [7:0] fst, input int lat, input int rdy_dly);
    logic [31:0] e_data;
    logic [4:0]  e_flags;
    logic        e_tmo;
    int e_lat, e_act, e_clr, cyc, n_act, n_clr;
    bit got;
    if (op > 3'd4) begin
      e_data = QNAN; e_flags = 5'b10000; e_tmo = 1'b0; e_lat = 1; e_act = 0; e_clr = 0;
    end else if (lat == 0 || lat > TIMEOUT) begin
      e_data = QNAN; e_flags = 5'b10000; e_tmo = 1'b1;
      e_lat = RST_CYC + 1 + TIMEOUT; e_act = TIMEOUT; e_clr = RST_CYC;
    end else begin
      e_tmo = 1'b0; e_lat = RST_CYC + 1 + lat; e_act = lat; e_clr = RST_CYC;
      if (op == 3'd4) begin
        e_data  = {29'd0, fst[0], fst[1], fst[2]};
        e_flags = {fst[5], 4'b0000};
      end else begin
        e_data  = fout;
        e_flags = {fst[5], (op == 3'd3) ? 1'b0 : fst[3], fst[7], fst[6], fst[4]};
      end
    end
    fpu_out = fout; fpu_st = fst; fpu_lat = lat;
    rsp_ready_i = (rdy_dly < 0);
    @(negedge clk_i);
    cyc = 0;
    while (!req_ready_o && cyc < 50) begin @(negedge clk_i); cyc++; end
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL req_ready_idle: got %b want 1", req_ready_o); end
    req_valid_i = 1'b1; req_op_i = op; req_a_i = a; req_b_i = b; req_rm_i = rm; req_tag_i = tag;
    cyc = 0; n_act = 0; n_clr = 0; got = 0;
    while (!got && cyc < e_lat + 20) begin
      @(negedge clk_i);
      req_valid_i = 1'b0; req_a_i = $urandom; req_b_i = $urandom;
      cyc++;
      if (act_o) n_act++;
      if (fpu_rst_o) n_clr++;
      if (act_o || fpu_rst_o) begin
        checks++;
        if ({in1p_o, in2p_o, opcode_o, round_mp_o} !== {a, b, op, rm} || (act_o && fpu_rst_o)) begin
          errors++;
          $display("FAIL fpu_drive: got a=%h b=%h op=%0d rm=%0d act=%b rst=%b want a=%h b=%h op=%0d rm=%0d",
                   in1p_o, in2p_o, opcode_o, round_mp_o, act_o, fpu_rst_o, a, b, op, rm);
        end
      end
      if (rsp_valid_o) got = 1;
    end
    checks++;
    if (!got || cyc != e_lat) begin errors++; $display("FAIL latency: got %0d (valid=%b) want %0d", cyc, got, e_lat); end
    checks++;
    if (n_act != e_act || n_clr != e_clr) begin
      errors++; $display("FAIL phase_len: got act=%0d clr=%0d want act=%0d clr=%0d", n_act, n_clr, e_act, e_clr);
    end
    for (int i = 0; i <= (rdy_dly < 0 ? 0 : rdy_dly); i++) begin
      if (i > 0) @(negedge clk_i);
      checks++;
      if ({rsp_valid_o, rsp_data_o, rsp_flags_o, rsp_tag_o, rsp_timeout_o, req_ready_o, act_o, fpu_rst_o, in1p_o, in2p_o, opcode_o}
          !== {1'b1, e_data, e_flags, tag, e_tmo, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0}) begin
        errors++;
        $display("FAIL response: got v=%b d=%h f=%b t=%h to=%b rr=%b act=%b in1=%h want v=1 d=%h f=%b t=%h to=%b rr=0",
                 rsp_valid_o, rsp_data_o, rsp_flags_o, rsp_tag_o, rsp_timeout_o, req_ready_o, act_o, in1p_o,
                 e_data, e_flags, tag, e_tmo);
      end
    end
    rsp_ready_i = 1'b1;
`ifdef FPU_ISSUER_STICKY_EN
    clr_flags_i = clr_with_hs;
    sticky_m = clr_with_hs ? e_flags : (sticky_m | e_flags);
`else
    sticky_m = sticky_m | e_flags;
`endif
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
`ifdef FPU_ISSUER_STICKY_EN
    clr_flags_i = 1'b0;
    checks++;
    if (sticky_flags_o !== sticky_m) begin errors++; $display("FAIL sticky: got %b want %b", sticky_flags_o, sticky_m); end
`endif
    checks++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++; $display("FAIL after_hs: got valid=%b ready=%b want valid=0 ready=1", rsp_valid_o, req_ready_o);
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({req_ready_o, rsp_valid_o, act_o, fpu_rst_o, in1p_o, in2p_o, opcode_o, round_mp_o, rsp_data_o, rsp_flags_o, rsp_tag_o, rsp_timeout_o}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 3'd0, 32'd0, 5'd0, 4'd0, 1'b0}) begin
      errors++; $display("FAIL reset_state: got ready=%b valid=%b act=%b frst=%b want ready=1 others 0",
                         req_ready_o, rsp_valid_o, act_o, fpu_rst_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    sticky_m = '0;
  endtask

  task automatic test_directed;
    do_op(3'd0, 32'h3F80_0000, 32'h4000_0000, 3'd0, 4'd3, 32'h4040_0000, 8'h00, 2, 0);
    do_op(3'd2, 32'h3F80_0000, 32'h0000_0000, 3'd1, 4'd7, 32'h7F80_0000, 8'b0000_1000, 3, 1);
    do_op(3'd4, 32'h4000_0000, 32'h3F80_0000, 3'd0, 4'd9, 32'h1234_5678, 8'b1111_1001, 1, 0);
    do_op(3'd5, 32'h1111_1111, 32'h2222_2222, 3'd2, 4'd4, 32'h0, 8'h00, 1, 0);
    do_op(3'd3, 32'h4080_0000, 32'hDEAD_BEEF, 3'd3, 4'd1, 32'h4000_0000, 8'b0001_1000, 1, 0);
  endtask

  task automatic test_timeout;
    do_op(3'd1, 32'h4000_0000, 32'h4000_0000, 3'd0, 4'd5, 32'h4080_0000, 8'h00, 0, 0);
    do_op(3'd1, 32'h4000_0000, 32'h4000_0000, 3'd0, 4'd6, 32'h4080_0000, 8'h10, TIMEOUT, 0);
    do_op(3'd0, 32'h4000_0000, 32'h4000_0000, 3'd0, 4'd2, 32'h4080_0000, 8'h00, TIMEOUT + 1, 0);
  endtask

  task automatic test_stall;
    do_op(3'd1, 32'h4040_0000, 32'h4000_0000, 3'd4, 4'hA, 32'h40C0_0000, 8'b1101_0000, 4, 10);
  endtask

  task automatic test_done_ignored;
    done_force = 1'b1;
    repeat (3) @(negedge clk_i);
    do_op(3'd0, 32'h3F00_0000, 32'h3F00_0000, 3'd0, 4'hC, 32'h3F80_0000, 8'h00, 3, -1);
    done_force = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    fpu_lat = 0;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_op_i = 3'd1; req_a_i = 32'h4000_0000; req_b_i = 32'h4000_0000; req_tag_i = 4'd8;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    cyc = 0;
    while (!act_o && cyc < 20) begin @(negedge clk_i); cyc++; end
    @(negedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    checks++;
    if ({act_o, fpu_rst_o, rsp_valid_o, req_ready_o} !== 4'b0001) begin
      errors++; $display("FAIL async_abort: got act=%b frst=%b valid=%b ready=%b want 0 0 0 1",
                         act_o, fpu_rst_o, rsp_valid_o, req_ready_o);
    end
    sticky_m = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    checks++;
    if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL no_rsp_after_abort: got %b want 0", rsp_valid_o); end
    do_op(3'd0, 32'h3F80_0000, 32'h4000_0000, 3'd0, 4'd3, 32'h4040_0000, 8'h00, 1, 0);
  endtask

`ifdef FPU_ISSUER_STICKY_EN
  task automatic test_sticky;
    @(negedge clk_i);
    clr_flags_i = 1'b1;
    sticky_m = '0;
    @(negedge clk_i);
    clr_flags_i = 1'b0;
    checks++;
    if (sticky_flags_o !== 5'd0) begin errors++; $display("FAIL sticky_clr: got %b want 0", sticky_flags_o); end
    do_op(3'd0, 32'h1, 32'h2, 3'd0, 4'd1, 32'h3, 8'b1000_0000, 1, 0);
    clr_with_hs = 1'b1;
    do_op(3'd0, 32'h1, 32'h2, 3'd0, 4'd2, 32'h3, 8'b0001_0000, 1, 0);
    clr_with_hs = 1'b0;
  endtask
`endif

  task automatic test_random;
    for (int n = 0; n < 30; n++) begin
      do_op(3'($urandom_range(0, 7)), $urandom, $urandom, 3'($urandom_range(0, 7)),
            TAG_W'($urandom), $urandom, 8'($urandom), $urandom_range(0, TIMEOUT + 2),
            $urandom_range(0, 4) - 1);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_timeout;
    test_stall;
    test_done_ignored;
    test_reset_mid_run;
`ifdef FPU_ISSUER_STICKY_EN
    test_sticky;
`endif
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end
endmodule
